// File: rtl/sp_wb_word_bridge.sv
// Byte-wide Wishbone slave to 16-bit big-endian word master, with a one-word read buffer
// and a watchdog that completes any access the system bus never acknowledges.
module sp_wb_word_bridge #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TMO_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:23]  s_adr_i,
  input  logic [0:7]   s_dat_i,
  output logic [0:7]   s_dat_o,
  input  logic         s_we_i,
  input  logic [0:0]   s_sel_i,
  input  logic         s_stb_i,
  input  logic         s_cyc_i,
  output logic         s_ack_o,
  output logic [0:22]  m_adr_o,
  output logic [0:15]  m_dat_o,
  input  logic [0:15]  m_dat_i,
  output logic         m_we_o,
  output logic [0:1]   m_sel_o,
  output logic         m_stb_o,
  output logic         m_cyc_o,
  input  logic         m_ack_i,
  output logic         err_o,
  output logic [0:23]  err_adr_o,
  input  logic         err_clr_i
);

  typedef enum logic [1:0] {StIdle, StBus, StAck} state_e;

  state_e             state_q, state_d;
  logic               s_ack_q, s_ack_d;
  logic [0:7]         s_dat_q, s_dat_d;
  logic               m_cyc_q, m_cyc_d;
  logic               m_we_q, m_we_d;
  logic [0:1]         m_sel_q, m_sel_d;
  logic [0:22]        m_adr_q, m_adr_d;
  logic [0:15]        m_dat_q, m_dat_d;
  logic               lane_q, lane_d;
  logic               err_q, err_d;
  logic [0:23]        err_adr_q, err_adr_d;
  logic [0:15]        buf_q, buf_d;
  logic [0:22]        tag_q, tag_d;
  logic               valid_q, valid_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               tmo_fire;

  always_comb begin
    state_d   = state_q;
    s_ack_d   = 1'b0;
    s_dat_d   = s_dat_q;
    m_cyc_d   = m_cyc_q;
    m_we_d    = m_we_q;
    m_sel_d   = m_sel_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    lane_d    = lane_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    buf_d     = buf_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    tmo_d     = tmo_q;
    tmo_fire  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_cyc_i && s_stb_i) begin
          if (!s_we_i && valid_q && (tag_q == s_adr_i[0:22])) begin
            state_d = StAck;
            s_ack_d = 1'b1;
            s_dat_d = s_adr_i[23] ? buf_q[8:15] : buf_q[0:7];
          end else if (!s_we_i || s_sel_i[0]) begin
            state_d = StBus;
            m_cyc_d = 1'b1;
            m_we_d  = s_we_i;
            m_adr_d = s_adr_i[0:22];
            lane_d  = s_adr_i[23];
            tmo_d   = '0;
            if (s_we_i) begin
              m_sel_d = s_adr_i[23] ? 2'b01 : 2'b10;
              m_dat_d = {s_dat_i, s_dat_i};
            end else begin
              m_sel_d = 2'b11;
            end
          end else begin
            // Write with no byte selected completes without touching the system bus.
            state_d = StAck;
            s_ack_d = 1'b1;
          end
        end
      end
      StBus: begin
        if (!s_cyc_i || m_ack_i || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          m_cyc_d = 1'b0;
          m_we_d  = 1'b0;
          m_sel_d = 2'b00;
        end
        if (!s_cyc_i) begin
          state_d = StIdle;
        end else if (m_ack_i) begin
          state_d = StAck;
          s_ack_d = 1'b1;
          if (!m_we_q) begin
            buf_d   = m_dat_i;
            tag_d   = m_adr_q;
            valid_d = 1'b1;
            s_dat_d = lane_q ? m_dat_i[8:15] : m_dat_i[0:7];
          end else if (valid_q && (tag_q == m_adr_q)) begin
            if (lane_q) buf_d[8:15] = m_dat_q[8:15];
            else        buf_d[0:7]  = m_dat_q[0:7];
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d  = StAck;
          s_ack_d  = 1'b1;
          tmo_fire = 1'b1;
          if (!m_we_q) s_dat_d = 8'hFF;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (err_clr_i) err_d = 1'b0;
    // A timeout coinciding with a clear wins and records the new address.
    if (tmo_fire) begin
      err_d = 1'b1;
      if (!err_q || err_clr_i) err_adr_d = {m_adr_q, lane_q};
    end

    if (!s_cyc_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      s_ack_q   <= 1'b0;
      s_dat_q   <= '0;
      m_cyc_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_sel_q   <= '0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      lane_q    <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
      buf_q     <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
      m_cyc_q   <= m_cyc_d;
      m_we_q    <= m_we_d;
      m_sel_q   <= m_sel_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      lane_q    <= lane_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
      buf_q     <= buf_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
    end
  end

  assign s_ack_o   = s_ack_q;
  assign s_dat_o   = s_dat_q;
  assign m_cyc_o   = m_cyc_q;
  assign m_stb_o   = m_cyc_q;
  assign m_we_o    = m_we_q;
  assign m_sel_o   = m_sel_q;
  assign m_adr_o   = m_adr_q;
  assign m_dat_o   = m_dat_q;
  assign err_o     = err_q;
  assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_sp_wb_word_bridge.sv
// Directed bench for sp_wb_word_bridge: buffered reads, writes, write-through,
// timeout/error flag, reset mid-access and cycle abort.
module tb_sp_wb_word_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:23]  s_adr_i;
  logic [0:7]   s_dat_i;
  logic [0:7]   s_dat_o;
  logic         s_we_i;
  logic [0:0]   s_sel_i;
  logic         s_stb_i;
  logic         s_cyc_i;
  logic         s_ack_o;
  logic [0:22]  m_adr_o;
  logic [0:15]  m_dat_o;
  logic [0:15]  m_dat_i;
  logic         m_we_o;
  logic [0:1]   m_sel_o;
  logic         m_stb_o;
  logic         m_cyc_o;
  logic         m_ack_i;
  logic         err_o;
  logic [0:23]  err_adr_o;
  logic         err_clr_i;

  logic         ack_en;
  logic         late_ack;
  int           total = 0;
  int           bad = 0;

  // Downstream monitor
  int           dn_reads = 0;
  int           dn_writes = 0;
  int           stb_cycles = 0;
  logic [0:22]  last_adr;
  logic [0:1]   last_sel;
  logic [0:15]  last_dat;
  logic         last_we;

  always #5 clk = ~clk;

  sp_wb_word_bridge #(.TIMEOUT(8), .TMO_W(16)) dut (
    .clk(clk), .reset(reset),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i),
    .err_o(err_o), .err_adr_o(err_adr_o), .err_clr_i(err_clr_i)
  );

  assign m_ack_i = (ack_en & m_stb_o) | late_ack;

  always_comb begin
    case (m_adr_o)
      23'h091A00: m_dat_i = 16'hA1B2;
      23'h091A01: m_dat_i = 16'hC3D4;
      23'h000080: m_dat_i = 16'h1234;
      default:    m_dat_i = 16'hDEAD;
    endcase
  end

  always @(posedge clk) begin
    if (m_stb_o) stb_cycles <= stb_cycles + 1;
    if (m_stb_o && m_ack_i) begin
      if (m_we_o) dn_writes <= dn_writes + 1;
      else        dn_reads  <= dn_reads + 1;
      last_adr <= m_adr_o;
      last_sel <= m_sel_o;
      last_dat <= m_dat_o;
      last_we  <= m_we_o;
    end
  end

  // Presents one SP access (cyc/stb left high) and waits up to 40 cycles for s_ack_o.
  // lat = cycles from request edge to ack, -1 if no ack. Returns at the cycle after ACK.
  task automatic sp_access(input logic [0:23] adr, input logic we, input logic [0:7] dat,
                           input logic sel, output logic [0:7] rdata, output int lat);
    s_adr_i = adr;
    s_we_i  = we;
    s_dat_i = dat;
    s_sel_i = sel;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    lat     = -1;
    rdata   = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (s_ack_o) begin
        rdata = s_dat_o;
        lat   = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic sp_idle();
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s_ack_o, m_cyc_o, m_stb_o, m_we_o, err_o, m_sel_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ack/cyc/stb/we/err/sel=%b want 0000000",
               {s_ack_o, m_cyc_o, m_stb_o, m_we_o, err_o, m_sel_o});
    end
    total++;
    if ({s_dat_o, m_adr_o, m_dat_o, err_adr_o} !== 71'b0) begin
      bad++;
      $display("FAIL reset_data: dat=%h adr=%h mdat=%h erradr=%h want all 0",
               s_dat_o, m_adr_o, m_dat_o, err_adr_o);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_burst_read();
    logic [0:7]  exp_dat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int          exp_lat [4] = '{2, 1, 2, 1};
    logic [0:22] exp_adr [4] = '{23'h091A00, 23'h091A00, 23'h091A01, 23'h091A01};
    logic [0:7]  rd;
    int          lat;
    int          r0;
    r0 = dn_reads;
    for (int i = 0; i < 4; i++) begin
      sp_access(24'h123400 + 24'(i), 1'b0, 8'h00, 1'b1, rd, lat);
      total++;
      if (rd !== exp_dat[i] || lat != exp_lat[i]) begin
        bad++;
        $display("FAIL burst_read[%0d]: got dat=%h lat=%0d want dat=%h lat=%0d",
                 i, rd, lat, exp_dat[i], exp_lat[i]);
      end
      total++;
      if (last_adr !== exp_adr[i] || last_sel !== 2'b11 || last_we !== 1'b0) begin
        bad++;
        $display("FAIL burst_dn[%0d]: got adr=%h sel=%b we=%b want adr=%h sel=11 we=0",
                 i, last_adr, last_sel, last_we, exp_adr[i]);
      end
    end
    total++;
    if (dn_reads - r0 != 2) begin
      bad++;
      $display("FAIL burst_count: got %0d downstream reads want 2", dn_reads - r0);
    end
    sp_idle();
  endtask

  task automatic test_write();
    logic [0:7] rd;
    int         lat;
    int         w0;
    w0 = dn_writes;
    sp_access(24'h000101, 1'b1, 8'h55, 1'b1, rd, lat);
    total++;
    if (lat != 2 || dn_writes - w0 != 1) begin
      bad++;
      $display("FAIL write_lat: got lat=%0d writes=%0d want lat=2 writes=1", lat, dn_writes - w0);
    end
    total++;
    if (last_adr !== 23'h000080 || last_sel !== 2'b01 || last_dat !== 16'h5555 ||
        last_we !== 1'b1) begin
      bad++;
      $display("FAIL write_dn: got adr=%h sel=%b dat=%h we=%b want 000080 01 5555 1",
               last_adr, last_sel, last_dat, last_we);
    end
    sp_idle();
  endtask

  task automatic test_write_through();
    logic [0:7] rd;
    int         lat;
    int         r0;
    sp_access(24'h000100, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'h12 || lat != 2) begin
      bad++;
      $display("FAIL wt_fill: got dat=%h lat=%0d want 12 lat=2", rd, lat);
    end
    sp_access(24'h000101, 1'b1, 8'h99, 1'b1, rd, lat);
    r0 = dn_reads;
    sp_access(24'h000101, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'h99 || lat != 1 || dn_reads != r0) begin
      bad++;
      $display("FAIL wt_hit: got dat=%h lat=%0d newreads=%0d want 99 lat=1 newreads=0",
               rd, lat, dn_reads - r0);
    end
    sp_idle();
    r0 = dn_reads;
    sp_access(24'h000100, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'h12 || lat != 2 || dn_reads - r0 != 1) begin
      bad++;
      $display("FAIL wt_refetch: got dat=%h lat=%0d reads=%0d want 12 lat=2 reads=1",
               rd, lat, dn_reads - r0);
    end
    sp_idle();
  endtask

  task automatic test_timeout();
    logic [0:7] rd;
    int         lat;
    int         s0;
    ack_en = 1'b0;
    s0 = stb_cycles;
    sp_access(24'h800010, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'hFF || lat != 9 || stb_cycles - s0 != 8) begin
      bad++;
      $display("FAIL tmo_first: got dat=%h lat=%0d stb=%0d want FF lat=9 stb=8",
               rd, lat, stb_cycles - s0);
    end
    total++;
    if (err_o !== 1'b1 || err_adr_o !== 24'h800010) begin
      bad++;
      $display("FAIL tmo_err: got err=%b adr=%h want 1 800010", err_o, err_adr_o);
    end
    sp_access(24'h800020, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'hFF || lat != 9 || err_o !== 1'b1 || err_adr_o !== 24'h800010) begin
      bad++;
      $display("FAIL tmo_second: got dat=%h lat=%0d err=%b adr=%h want FF 9 1 800010",
               rd, lat, err_o, err_adr_o);
    end
    sp_idle();
    err_clr_i = 1'b1;
    @(posedge clk); #1;
    err_clr_i = 1'b0;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: got err=%b want 0", err_o);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_bus();
    logic [0:7] rd;
    int         lat;
    int         r0;
    sp_access(24'h123400, 1'b0, 8'h00, 1'b1, rd, lat);
    ack_en  = 1'b0;
    s_adr_i = 24'h800010;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_stb_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup: got stb=%b want 1", m_stb_o);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || s_ack_o !== 1'b0 || err_adr_o !== 24'h0) begin
      bad++;
      $display("FAIL rst_mid: got cyc=%b stb=%b ack=%b erradr=%h want 0 0 0 0",
               m_cyc_o, m_stb_o, s_ack_o, err_adr_o);
    end
    @(posedge clk); #1;
    reset  = 1'b1;
    ack_en = 1'b1;
    r0 = dn_reads;
    sp_access(24'h123401, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'hB2 || lat != 2 || dn_reads - r0 != 1) begin
      bad++;
      $display("FAIL rst_refetch: got dat=%h lat=%0d reads=%0d want B2 lat=2 reads=1",
               rd, lat, dn_reads - r0);
    end
    sp_idle();
  endtask

  task automatic test_cyc_drop();
    logic [0:7] rd;
    int         lat;
    logic       seen_ack;
    ack_en  = 1'b0;
    s_adr_i = 24'h000200;
    s_we_i  = 1'b0;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_bus: got cyc=%b stb=%b want 0 0", m_cyc_o, m_stb_o);
    end
    late_ack = 1'b1;
    seen_ack = s_ack_o;
    @(posedge clk); #1;
    late_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_ack |= s_ack_o;
      @(posedge clk); #1;
    end
    total++;
    if (seen_ack !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_late_ack: got ack_seen=%b err=%b want 0 0", seen_ack, err_o);
    end
    ack_en = 1'b1;
    sp_access(24'h000100, 1'b0, 8'h00, 1'b1, rd, lat);
    total++;
    if (rd !== 8'h12 || lat != 2) begin
      bad++;
      $display("FAIL drop_recover: got dat=%h lat=%0d want 12 lat=2", rd, lat);
    end
    sp_idle();
  endtask

  initial begin
    reset     = 1'b0;
    s_adr_i   = '0;
    s_dat_i   = '0;
    s_we_i    = 1'b0;
    s_sel_i   = 1'b0;
    s_stb_i   = 1'b0;
    s_cyc_i   = 1'b0;
    err_clr_i = 1'b0;
    ack_en    = 1'b1;
    late_ack  = 1'b0;
    test_reset();
    test_burst_read();
    test_write();
    test_write_through();
    test_timeout();
    test_reset_mid_bus();
    test_cyc_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
